// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, requester and error-data definitions for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;
  typedef enum logic {REQ_IF, REQ_LS} requester_t;
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; ports: clk, reset, req[0]=IF/req[1]=LS, update strobe, one-hot grant
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);
  requester_t last;
  always_comb grant = &req ? (last == REQ_LS ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk or posedge reset)
    if (reset) last <= REQ_LS;
    else if (update && |grant) last <= grant[1] ? REQ_LS : REQ_IF;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one Avalon-style memory port between the IF and LS ports; ports: clk/reset, IF port, LS port, memory port, sticky o_bus_err
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255,
  parameter logic [DW-1:0] ERR_DATA = DW'(DEF_ERR_DATA)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   i_if_addr,
  input  logic            i_if_rd,
  output logic [DW-1:0]   o_if_rddata,
  output logic            o_if_waitrequest,
  output logic            o_if_rddatavalid,
  input  logic [AW-1:0]   i_ls_addr,
  input  logic            i_ls_rd,
  input  logic            i_ls_wr,
  input  logic [DW-1:0]   i_ls_wrdata,
  input  logic [DW/8-1:0] i_ls_byte_en,
  output logic [DW-1:0]   o_ls_rddata,
  output logic            o_ls_waitrequest,
  output logic            o_ls_rddatavalid,
  output logic [AW-1:0]   o_mem_addr,
  output logic            o_mem_rd,
  output logic            o_mem_wr,
  output logic [DW-1:0]   o_mem_wrdata,
  output logic [DW/8-1:0] o_mem_byte_en,
  input  logic            i_mem_waitrequest,
  input  logic [DW-1:0]   i_mem_rddata,
  input  logic            i_mem_rddatavalid,
  output logic            o_bus_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  state_t state;
  requester_t owner;
  logic [CW-1:0] cnt;
  logic [1:0] grant;
  logic accept, rvalid, timeout;
  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({i_ls_rd | i_ls_wr, i_if_rd}),
    .update (state == IDLE),
    .grant  (grant)
  );
  // Acceptance and read completion follow the memory handshake in the same cycle
  always_comb begin
    accept = state == ISSUE && !i_mem_waitrequest;
    rvalid = state == RDWAIT && (i_mem_rddatavalid || cnt == TMAX);
    timeout = rvalid && !i_mem_rddatavalid;
    o_if_waitrequest = !(accept && owner == REQ_IF);
    o_ls_waitrequest = !(accept && owner == REQ_LS);
    o_if_rddatavalid = rvalid && owner == REQ_IF;
    o_ls_rddatavalid = rvalid && owner == REQ_LS;
    o_if_rddata = timeout ? ERR_DATA : i_mem_rddata;
    o_ls_rddata = timeout ? ERR_DATA : i_mem_rddata;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      owner <= REQ_IF;
      cnt <= '0;
      o_mem_addr <= '0;
      o_mem_rd <= 1'b0;
      o_mem_wr <= 1'b0;
      o_mem_wrdata <= '0;
      o_mem_byte_en <= '0;
      o_bus_err <= 1'b0;
    end else begin
      if ((i_mem_rddatavalid && state != RDWAIT) || timeout) o_bus_err <= 1'b1;
      case (state)
        IDLE:
          if (|grant) begin
            state <= ISSUE;
            owner <= grant[1] ? REQ_LS : REQ_IF;
            o_mem_addr <= grant[1] ? i_ls_addr : i_if_addr;
            o_mem_rd <= grant[1] ? i_ls_rd & ~i_ls_wr : 1'b1;
            o_mem_wr <= grant[1] & i_ls_wr;
            o_mem_wrdata <= grant[1] ? i_ls_wrdata : '0;
            o_mem_byte_en <= grant[1] ? i_ls_byte_en : '1;
            // Simultaneous load and store: the store wins and the misuse is flagged
            if (grant[1] && i_ls_rd && i_ls_wr) o_bus_err <= 1'b1;
          end
        ISSUE:
          if (!i_mem_waitrequest) begin
            o_mem_rd <= 1'b0;
            o_mem_wr <= 1'b0;
            cnt <= '0;
            state <= o_mem_rd ? RDWAIT : IDLE;
          end
        RDWAIT: begin
          cnt <= cnt == TMAX ? cnt : cnt + 1'b1;
          if (rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic        clk = 0, reset = 1;
  logic [31:0] if_addr = 0, ls_addr = 0, ls_wrdata = 0, mem_rddata = 0;
  logic        if_rd = 0, ls_rd = 0, ls_wr = 0, mem_waitrequest = 0, mem_rddatavalid = 0;
  logic [3:0]  ls_byte_en = 0;
  logic [31:0] if_rddata, ls_rddata, mem_addr, mem_wrdata;
  logic        if_waitrequest, if_rddatavalid, ls_waitrequest, ls_rddatavalid;
  logic        mem_rd, mem_wr, bus_err;
  logic [3:0]  mem_byte_en;
  int checks = 0, errors = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .i_if_addr(if_addr), .i_if_rd(if_rd), .o_if_rddata(if_rddata),
    .o_if_waitrequest(if_waitrequest), .o_if_rddatavalid(if_rddatavalid),
    .i_ls_addr(ls_addr), .i_ls_rd(ls_rd), .i_ls_wr(ls_wr), .i_ls_wrdata(ls_wrdata),
    .i_ls_byte_en(ls_byte_en), .o_ls_rddata(ls_rddata),
    .o_ls_waitrequest(ls_waitrequest), .o_ls_rddatavalid(ls_rddatavalid),
    .o_mem_addr(mem_addr), .o_mem_rd(mem_rd), .o_mem_wr(mem_wr),
    .o_mem_wrdata(mem_wrdata), .o_mem_byte_en(mem_byte_en),
    .i_mem_waitrequest(mem_waitrequest), .i_mem_rddata(mem_rddata),
    .i_mem_rddatavalid(mem_rddatavalid), .o_bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  initial begin
    // reset values
    tick();
    tick();
    #1;
    chk("rst_if_wait", if_waitrequest, 1);
    chk("rst_ls_wait", ls_waitrequest, 1);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_byte_en", mem_byte_en, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_if_valid", if_rddatavalid, 0);
    chk("rst_ls_valid", ls_rddatavalid, 0);
    reset = 0;

    // IF read, data 3 cycles after acceptance
    tick();
    if_rd = 1;
    if_addr = 32'h40;
    #1;
    chk("if_idle_wait", if_waitrequest, 1);
    tick();
    #1;
    chk("if_issue_rd", mem_rd, 1);
    chk("if_issue_addr", mem_addr, 32'h40);
    chk("if_issue_be", mem_byte_en, 4'hf);
    chk("if_accept_wait", if_waitrequest, 0);
    chk("if_accept_lswait", ls_waitrequest, 1);
    if_rd = 0;
    tick();
    #1;
    chk("if_rdwait_rd", mem_rd, 0);
    chk("if_rdwait_wait", if_waitrequest, 1);
    chk("if_rdwait_valid", if_rddatavalid, 0);
    tick();
    tick();
    mem_rddata = 32'h00000013;
    mem_rddatavalid = 1;
    #1;
    chk("if_valid", if_rddatavalid, 1);
    chk("if_data", if_rddata, 32'h00000013);
    chk("if_ls_valid", ls_rddatavalid, 0);
    tick();
    mem_rddatavalid = 0;
    #1;
    chk("if_valid_end", if_rddatavalid, 0);
    chk("if_no_err", bus_err, 0);

    // round-robin under continuous contention, right after reset
    pulse_reset();
    if_rd = 1;
    if_addr = 32'h1000;
    ls_rd = 1;
    ls_addr = 32'h2000;
    ls_byte_en = 4'hf;
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      chk("rr_addr", mem_addr, (k % 2 == 0) ? 32'h1000 : 32'h2000);
      chk("rr_rd", mem_rd, 1);
      tick();
      mem_rddatavalid = 1;
      mem_rddata = k;
      #1;
      chk("rr_if_valid", if_rddatavalid, (k % 2 == 0) ? 1 : 0);
      chk("rr_ls_valid", ls_rddatavalid, (k % 2 == 1) ? 1 : 0);
      tick();
      mem_rddatavalid = 0;
    end
    if_rd = 0;
    ls_rd = 0;
    #1;
    chk("rr_no_err", bus_err, 0);

    // LS write stalled 4 cycles by memory
    tick();
    ls_wr = 1;
    ls_addr = 32'h100;
    ls_wrdata = 32'hCAFEF00D;
    ls_byte_en = 4'b0011;
    mem_waitrequest = 1;
    tick();
    for (int c = 1; c <= 5; c++) begin
      mem_waitrequest = c < 5;
      #1;
      chk("wr_mem_wr", mem_wr, 1);
      chk("wr_mem_rd", mem_rd, 0);
      chk("wr_addr", mem_addr, 32'h100);
      chk("wr_data", mem_wrdata, 32'hCAFEF00D);
      chk("wr_be", mem_byte_en, 4'b0011);
      chk("wr_ls_wait", ls_waitrequest, c < 5 ? 1 : 0);
      if (c == 5) ls_wr = 0;
      tick();
    end
    mem_waitrequest = 0;
    #1;
    chk("wr_idle_wr", mem_wr, 0);
    chk("wr_idle_wait", ls_waitrequest, 1);
    chk("wr_no_valid", ls_rddatavalid, 0);
    tick();
    #1;
    chk("wr_stays_idle", mem_wr | mem_rd, 0);

    // LS read never answered: timeout after 8 RDWAIT cycles
    ls_rd = 1;
    ls_addr = 32'h200;
    ls_byte_en = 4'hf;
    tick();
    #1;
    chk("to_accept", ls_waitrequest, 0);
    ls_rd = 0;
    tick();
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("to_wait_valid", ls_rddatavalid, 0);
      tick();
    end
    #1;
    chk("to_valid", ls_rddatavalid, 1);
    chk("to_data", ls_rddata, 32'hDEADBEEF);
    chk("to_if_valid", if_rddatavalid, 0);
    chk("to_err_pre", bus_err, 0);
    tick();
    #1;
    chk("to_err", bus_err, 1);
    chk("to_valid_end", ls_rddatavalid, 0);
    tick();
    tick();
    #1;
    chk("to_err_sticky", bus_err, 1);

    // reset during RDWAIT, late data while reset is held
    pulse_reset();
    #1;
    chk("mr_err_cleared", bus_err, 0);
    if_rd = 1;
    if_addr = 32'h80;
    tick();
    if_rd = 0;
    tick();
    #1;
    chk("mr_in_rdwait", mem_rd, 0);
    reset = 1;
    #1;
    chk("mr_rd", mem_rd, 0);
    chk("mr_addr", mem_addr, 0);
    chk("mr_be", mem_byte_en, 0);
    chk("mr_if_wait", if_waitrequest, 1);
    mem_rddatavalid = 1;
    mem_rddata = 32'h12345678;
    #1;
    chk("mr_late_valid", if_rddatavalid, 0);
    tick();
    #1;
    chk("mr_late_valid2", if_rddatavalid, 0);
    mem_rddatavalid = 0;
    reset = 0;
    tick();
    #1;
    chk("mr_err_after", bus_err, 0);

    // stray read data outside RDWAIT flags an error
    mem_rddatavalid = 1;
    #1;
    chk("stray_no_valid", if_rddatavalid | ls_rddatavalid, 0);
    tick();
    mem_rddatavalid = 0;
    #1;
    chk("stray_err", bus_err, 1);

    // simultaneous load and store: write wins, error flagged
    pulse_reset();
    ls_rd = 1;
    ls_wr = 1;
    ls_addr = 32'h300;
    ls_wrdata = 32'h55AA55AA;
    tick();
    #1;
    chk("rw_mem_wr", mem_wr, 1);
    chk("rw_mem_rd", mem_rd, 0);
    chk("rw_data", mem_wrdata, 32'h55AA55AA);
    chk("rw_err", bus_err, 1);
    ls_rd = 0;
    ls_wr = 0;
    tick();
    #1;
    chk("rw_idle", mem_wr, 0);
    chk("rw_err_sticky", bus_err, 1);
    chk("rw_no_valid", ls_rddatavalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
